// File: rtl/line_memory_responder.sv
// line_memory_responder: memory-side responder for one cache line port.
// It accepts 4-word line reads and writes and answers each one after a fixed
// LATENCY with a one-cycle mem_ready pulse. The backing store holds MEM_WORDS
// 16-bit words and is word addressed.
// Optional build macro LINE_MEMORY_STATS_EN enables saturating completion
// counters. Without it, read_count and write_count are tied to zero.
module line_memory_responder #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_m,
    input  logic        write_m,
    input  logic [15:0] address_m,
    inout  wire  [63:0] data_m,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic [15:0] read_count,
    output logic [15:0] write_count
);

    localparam int unsigned LINES     = MEM_WORDS / 4;
    localparam int unsigned LINE_BITS = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t                 state, nextState;
    logic [3:0]             waitCnt, nextWaitCnt;
    logic                   opWrite, nextOpWrite;
    logic [LINE_BITS-1:0]   lineIdx, nextLineIdx;
    logic [63:0]            lineData;
    logic [15:0]            mem [MEM_WORDS];
    logic                   unusedAddr;

    // Address bits outside the line index only alias; fold them away.
    assign unusedAddr = ^address_m;

    // State and request registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            waitCnt <= '0;
            opWrite <= 1'b0;
            lineIdx <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            opWrite <= nextOpWrite;
            lineIdx <= nextLineIdx;
        end
    end

    // Next-state logic. A simultaneous read and write resolves to a write.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        nextOpWrite = opWrite;
        nextLineIdx = lineIdx;
        case (state)
            IDLE: begin
                if (read_m || write_m) begin
                    nextOpWrite = write_m;
                    nextLineIdx = address_m[LINE_BITS+1:2];
                    nextWaitCnt = 4'(LATENCY - 1);
                    nextState   = (LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                nextWaitCnt = waitCnt - 4'd1;
                if (waitCnt == 4'd1) nextState = RESPOND;
            end
            RESPOND: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Gather the four words of the latched line.
    always_comb begin
        lineData = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            lineData[16*k +: 16] = mem[{lineIdx, 2'(k)}];
        end
    end

    assign mem_ready = (state == RESPOND);
    assign mem_busy  = (state != IDLE);
    assign data_m    = (state == RESPOND && !opWrite) ? lineData : 64'bz;

    // The line is stored at the closing edge of a write RESPOND.
    // The array is not reset.
    always_ff @(posedge clk) begin
        if (state == RESPOND && opWrite) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[{lineIdx, 2'(k)}] <= data_m[16*k +: 16];
            end
        end
    end

`ifdef LINE_MEMORY_STATS_EN
    // Saturating completion counters that advance on each RESPOND cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (state == RESPOND) begin
            if (opWrite) begin
                if (write_count != '1) write_count <= write_count + 16'd1;
            end else begin
                if (read_count != '1) read_count <= read_count + 16'd1;
            end
        end
    end
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule
